// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data arbiter in front of the unified data_ram.
// Holds the state encodings, the requester select values and the grant decision helper.
package mem_arbiter_pkg;

   localparam int unsigned InstAddrBus = 32;
   localparam int unsigned RegBus      = 32;
   localparam int unsigned CntW        = 3;

   localparam logic [RegBus-1:0] ZeroWord = '0;
   localparam logic [3:0]        SelAll   = 4'b1111;

   localparam logic WhoIf  = 1'b0;
   localparam logic WhoMem = 1'b1;

   typedef enum logic [1:0] {
      ArbIdle,
      ArbBusy,
      ArbDone
   } arb_state_e;

   typedef struct packed {
      logic valid;
      logic who;
   } grant_t;

   // Both requesting: data wins unless it also won last time, so fetch cannot starve.
   function automatic grant_t arb_pick(input logic if_req,
                                       input logic mem_req,
                                       input logic last_who);
      grant_t g;
      g.valid = if_req | mem_req;
      if (if_req && mem_req) begin
         g.who = (last_who == WhoMem) ? WhoIf : WhoMem;
      end else begin
         g.who = mem_req ? WhoMem : WhoIf;
      end
      return g;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-request-at-a-time arbiter between instruction fetch and load/store onto data_ram.
// One operation is latched per grant; completion is signalled with a one-cycle ack.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned RAM_LAT = 1,
   parameter int unsigned ADDR_W  = InstAddrBus
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [RegBus-1:0] if_data_o,
   output logic              if_ack_o,

   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [3:0]        mem_sel_i,
   input  logic [RegBus-1:0] mem_wdata_i,
   output logic [RegBus-1:0] mem_rdata_o,
   output logic              mem_ack_o,

   output logic              ram_ce_o,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [3:0]        ram_sel_o,
   output logic [RegBus-1:0] ram_wdata_o,
   input  logic [RegBus-1:0] ram_rdata_i,

   output logic              who_o,
   output logic              stall_req_o
);

   localparam logic [CntW-1:0] LatInit = CntW'(RAM_LAT);

   arb_state_e        state_q, state_d;
   grant_t            grant;

   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [3:0]        sel_q;
   logic [RegBus-1:0] wdata_q;
   logic              who_q;
   logic              last_q;
   logic [CntW-1:0]   cnt_q;
   logic [RegBus-1:0] if_data_q;
   logic [RegBus-1:0] mem_rdata_q;

   always_comb begin
      grant = arb_pick(if_req_i, mem_req_i, last_q);
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ArbIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ArbIdle: begin
            if (grant.valid) begin
               state_d = ArbBusy;
            end
         end
         ArbBusy: begin
            // Stores finish after one RAM cycle; reads wait out the RAM latency.
            if (we_q || (cnt_q == '0)) begin
               state_d = ArbDone;
            end
         end
         ArbDone: begin
            state_d = ArbIdle;
         end
         default: begin
            state_d = ArbIdle;
         end
      endcase
   end

   // Command, counter and read-data registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q      <= '0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         wdata_q     <= ZeroWord;
         who_q       <= WhoIf;
         last_q      <= WhoIf;
         cnt_q       <= '0;
         if_data_q   <= ZeroWord;
         mem_rdata_q <= ZeroWord;
      end else begin
         unique case (state_q)
            ArbIdle: begin
               if (grant.valid) begin
                  who_q <= grant.who;
                  cnt_q <= LatInit;
                  if (grant.who == WhoMem) begin
                     addr_q  <= mem_addr_i;
                     we_q    <= mem_we_i;
                     sel_q   <= mem_sel_i;
                     wdata_q <= mem_wdata_i;
                  end else begin
                     addr_q  <= if_addr_i;
                     we_q    <= 1'b0;
                     sel_q   <= SelAll;
                     wdata_q <= ZeroWord;
                  end
               end
            end
            ArbBusy: begin
               if (!we_q) begin
                  if (cnt_q != '0) begin
                     cnt_q <= cnt_q - CntW'(1);
                  end else if (who_q == WhoMem) begin
                     mem_rdata_q <= ram_rdata_i;
                  end else begin
                     if_data_q <= ram_rdata_i;
                  end
               end
            end
            ArbDone: begin
               last_q <= who_q;
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs
   always_comb begin
      ram_ce_o    = (state_q == ArbBusy);
      ram_we_o    = (state_q == ArbBusy) && we_q;
      ram_addr_o  = addr_q;
      ram_sel_o   = sel_q;
      ram_wdata_o = wdata_q;
      who_o       = who_q;
      if_ack_o    = (state_q == ArbDone) && (who_q == WhoIf);
      mem_ack_o   = (state_q == ArbDone) && (who_q == WhoMem);
      if_data_o   = if_data_q;
      mem_rdata_o = mem_rdata_q;
      stall_req_o = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o);
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: four arbiters with RAM_LAT = 1..4, each in front of its own byte-masked RAM
// model with a read pipeline matching its latency.
module tb_mem_arbiter;

   localparam int unsigned NInst = 4;

   logic        clk;
   logic        rst;

   logic        if_req      [NInst];
   logic [31:0] if_addr     [NInst];
   logic [31:0] if_data     [NInst];
   logic        if_ack      [NInst];
   logic        mem_req     [NInst];
   logic        mem_we      [NInst];
   logic [31:0] mem_addr    [NInst];
   logic [3:0]  mem_sel     [NInst];
   logic [31:0] mem_wdata   [NInst];
   logic [31:0] mem_rdata   [NInst];
   logic        mem_ack     [NInst];
   logic        ram_ce      [NInst];
   logic        ram_we      [NInst];
   logic [31:0] ram_addr    [NInst];
   logic [3:0]  ram_sel     [NInst];
   logic [31:0] ram_wdata   [NInst];
   logic [31:0] ram_rdata   [NInst];
   logic        who         [NInst];
   logic        stall       [NInst];

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [31:0] init_word(input int idx);
      if (idx == 64) return 32'h0000_0013;
      if (idx < 128) return 32'h1000_0000 + 32'(idx * 4);
      return 32'h0;
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < NInst; g++) begin : g_dut
      logic [31:0] mem  [256];
      logic [31:0] pipe [NInst];

      mem_arbiter #(
         .RAM_LAT (g + 1),
         .ADDR_W  (32)
      ) u_dut (
         .clk         (clk),
         .rst         (rst),
         .if_req_i    (if_req[g]),
         .if_addr_i   (if_addr[g]),
         .if_data_o   (if_data[g]),
         .if_ack_o    (if_ack[g]),
         .mem_req_i   (mem_req[g]),
         .mem_we_i    (mem_we[g]),
         .mem_addr_i  (mem_addr[g]),
         .mem_sel_i   (mem_sel[g]),
         .mem_wdata_i (mem_wdata[g]),
         .mem_rdata_o (mem_rdata[g]),
         .mem_ack_o   (mem_ack[g]),
         .ram_ce_o    (ram_ce[g]),
         .ram_we_o    (ram_we[g]),
         .ram_addr_o  (ram_addr[g]),
         .ram_sel_o   (ram_sel[g]),
         .ram_wdata_o (ram_wdata[g]),
         .ram_rdata_i (ram_rdata[g]),
         .who_o       (who[g]),
         .stall_req_o (stall[g])
      );

      initial begin
         for (int i = 0; i < 256; i++) mem[i] = init_word(i);
         for (int s = 0; s < NInst; s++) pipe[s] = 32'h0;
      end

      always @(posedge clk) begin
         if (ram_ce[g] && ram_we[g]) begin
            for (int b = 0; b < 4; b++) begin
               if (ram_sel[g][b]) mem[ram_addr[g][9:2]][b*8 +: 8] <= ram_wdata[g][b*8 +: 8];
            end
         end
         pipe[0] <= mem[ram_addr[g][9:2]];
         for (int s = 1; s < NInst; s++) pipe[s] <= pipe[s-1];
      end

      assign ram_rdata[g] = pipe[g];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one request, waits for its ack, checks latency and read data, then releases it.
   task automatic do_xfer(input int k, input bit is_mem, input bit we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wdata, input int exp_lat,
                          input logic [31:0] exp_data, input string tag);
      int  lat;
      bit  got;
      if (is_mem) begin
         mem_req[k]   = 1'b1;
         mem_we[k]    = we;
         mem_addr[k]  = addr;
         mem_sel[k]   = sel;
         mem_wdata[k] = wdata;
      end else begin
         if_req[k]  = 1'b1;
         if_addr[k] = addr;
      end
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
         step();
         lat++;
         got = is_mem ? mem_ack[k] : if_ack[k];
      end
      check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      if (!we) check_eq({tag, "_data"}, is_mem ? mem_rdata[k] : if_data[k], exp_data);
      mem_req[k] = 1'b0;
      mem_we[k]  = 1'b0;
      if_req[k]  = 1'b0;
      step();
      check_eq({tag, "_ack_once"}, 32'(mem_ack[k] | if_ack[k]), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_done;
      int cyc;
      int first_if;
      int n_ack;
      int ack_cyc;

      rst = 1'b0;
      for (int k = 0; k < NInst; k++) begin
         if_req[k]    = 1'b0;
         if_addr[k]   = 32'h0;
         mem_req[k]   = 1'b0;
         mem_we[k]    = 1'b0;
         mem_addr[k]  = 32'h0;
         mem_sel[k]   = 4'h0;
         mem_wdata[k] = 32'h0;
      end
      step();
      step();
      for (int k = 0; k < NInst; k++) begin
         check_eq($sformatf("rst_ce%0d", k), 32'(ram_ce[k]), 32'h0);
         check_eq($sformatf("rst_addr%0d", k), ram_addr[k], 32'h0);
         check_eq($sformatf("rst_who%0d", k), 32'(who[k]), 32'h0);
         check_eq($sformatf("rst_ack%0d", k), 32'(if_ack[k] | mem_ack[k]), 32'h0);
      end
      #2 rst = 1'b1;
      step();

      // Asynchronous reset in the middle of a RAM_LAT=2 load
      mem_req[1]  = 1'b1;
      mem_addr[1] = 32'h10;
      mem_sel[1]  = 4'hF;
      step();
      check_eq("midrst_busy_ce", 32'(ram_ce[1]), 32'h1);
      check_eq("midrst_busy_addr", ram_addr[1], 32'h10);
      #2 rst = 1'b0;
      #1;
      check_eq("midrst_ce", 32'(ram_ce[1]), 32'h0);
      check_eq("midrst_addr", ram_addr[1], 32'h0);
      check_eq("midrst_who", 32'(who[1]), 32'h0);
      check_eq("midrst_sel", 32'(ram_sel[1]), 32'h0);
      mem_req[1] = 1'b0;
      #1 rst = 1'b1;
      step();
      do_xfer(1, 1'b0, 1'b0, 32'h0, 4'hF, 32'h0, 4, 32'h1000_0000, "postrst_fetch");

      // Single fetch, RAM_LAT=1
      if_req[0]  = 1'b1;
      if_addr[0] = 32'h100;
      #1;
      check_eq("fetch_stall_n", 32'(stall[0]), 32'h1);
      step();
      check_eq("fetch_addr_n1", ram_addr[0], 32'h100);
      check_eq("fetch_who_n1", 32'(who[0]), 32'h0);
      check_eq("fetch_stall_n1", 32'(stall[0]), 32'h1);
      step();
      check_eq("fetch_ack_n2", 32'(if_ack[0]), 32'h0);
      check_eq("fetch_stall_n2", 32'(stall[0]), 32'h1);
      step();
      check_eq("fetch_ack_n3", 32'(if_ack[0]), 32'h1);
      check_eq("fetch_data_n3", if_data[0], 32'h0000_0013);
      check_eq("fetch_stall_n3", 32'(stall[0]), 32'h0);
      if_req[0] = 1'b0;
      step();
      check_eq("fetch_ack_n4", 32'(if_ack[0]), 32'h0);

      // Byte-masked store then load, RAM_LAT=1
      mem_req[0]   = 1'b1;
      mem_we[0]    = 1'b1;
      mem_addr[0]  = 32'h200;
      mem_sel[0]   = 4'b0011;
      mem_wdata[0] = 32'hDEAD_BEEF;
      step();
      check_eq("st_we_n1", 32'(ram_we[0]), 32'h1);
      check_eq("st_sel_n1", 32'(ram_sel[0]), 32'h3);
      check_eq("st_wdata_n1", ram_wdata[0], 32'hDEAD_BEEF);
      check_eq("st_who_n1", 32'(who[0]), 32'h1);
      step();
      check_eq("st_we_n2", 32'(ram_we[0]), 32'h0);
      check_eq("st_ack_n2", 32'(mem_ack[0]), 32'h1);
      check_eq("st_rdata_kept", mem_rdata[0], 32'h0);
      mem_req[0] = 1'b0;
      mem_we[0]  = 1'b0;
      step();
      do_xfer(0, 1'b1, 1'b0, 32'h200, 4'hF, 32'h0, 3, 32'h0000_BEEF, "ld_after_st");
      do_xfer(0, 1'b1, 1'b1, 32'h204, 4'hF, 32'h1234_5678, 2, 32'h0, "st2");
      check_eq("st2_rdata_kept", mem_rdata[0], 32'h0000_BEEF);

      // Both requests held, RAM_LAT=3: data, fetch, data, fetch
      if_req[2]   = 1'b1;
      if_addr[2]  = 32'h0C;
      mem_req[2]  = 1'b1;
      mem_we[2]   = 1'b0;
      mem_addr[2] = 32'h80;
      mem_sel[2]  = 4'hF;
      n_done   = 0;
      cyc      = 0;
      first_if = -1;
      while (n_done < 4 && cyc < 60) begin
         step();
         cyc++;
         if (if_ack[2] || mem_ack[2]) begin
            check_eq($sformatf("alt_who%0d", n_done), 32'(who[2]),
                     (n_done % 2 == 0) ? 32'h1 : 32'h0);
            check_eq($sformatf("alt_memack%0d", n_done), 32'(mem_ack[2]),
                     (n_done % 2 == 0) ? 32'h1 : 32'h0);
            if (if_ack[2]) begin
               check_eq($sformatf("alt_ifdata%0d", n_done), if_data[2], 32'h1000_000C);
               if (first_if < 0) first_if = cyc;
            end else begin
               check_eq($sformatf("alt_memdata%0d", n_done), mem_rdata[2], 32'h1000_0080);
            end
            n_done++;
            if (n_done == 4) begin
               if_req[2]  = 1'b0;
               mem_req[2] = 1'b0;
            end
         end
      end
      check_eq("alt_count", 32'(n_done), 32'h4);
      check_eq("alt_fetch_bound", 32'((first_if > 0) && (first_if <= 11)), 32'h1);
      if_req[2]  = 1'b0;
      mem_req[2] = 1'b0;
      step();

      // One-cycle request pulse, RAM_LAT=4
      mem_req[3]  = 1'b1;
      mem_we[3]   = 1'b0;
      mem_addr[3] = 32'h44;
      mem_sel[3]  = 4'hF;
      step();
      mem_req[3] = 1'b0;
      n_ack   = (mem_ack[3] === 1'b1) ? 1 : 0;
      ack_cyc = 0;
      for (int c = 2; c <= 15; c++) begin
         step();
         if (mem_ack[3] === 1'b1) begin
            n_ack++;
            ack_cyc = c;
            check_eq("pulse_data", mem_rdata[3], 32'h1000_0044);
         end
      end
      check_eq("pulse_ack_count", 32'(n_ack), 32'h1);
      check_eq("pulse_ack_cycle", 32'(ack_cyc), 32'h6);

      // Load latency for each RAM_LAT
      for (int k = 0; k < NInst; k++) begin
         do_xfer(k, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 3 + k, 32'h1000_0040,
                 $sformatf("sweep_lat%0d", k + 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
